// File: rtl/attn_pkg.sv
// attn_pkg -- shared definitions for the attention datapath Transpose family.
//   cnt_w()     : counter width for a count of n items (never narrower than 1 bit)
//   ROW_W/COL_W : counter widths for the default ROW_IN x COL_IN tile
//   elem_lsb()  : LSB position of element idx inside a packed vector of
//                 width-bit elements (element 0 in the least significant slot)
package attn_pkg;

  localparam int DATA_WIDTH_DFLT = 16;
  localparam int ROW_IN_DFLT     = 8;
  localparam int COL_IN_DFLT     = 4;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ROW_W = cnt_w(ROW_IN_DFLT);
  localparam int COL_W = cnt_w(COL_IN_DFLT);

  function automatic int elem_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/stream_transpose_bank.sv
// transpose_bank -- one ROW_IN x COL_IN element store for stream_transpose.
//   clk, rst_n : clock, asynchronous active-low reset (contents cleared to 0)
//   we, wr_row, wr_data : write one whole input row (COL_IN elements)
//   rd_col, rd_data     : read one whole column (ROW_IN elements), combinational
//                         from the storage registers; element r of rd_data is
//                         row r at column rd_col
module transpose_bank
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int ROW_IN     = ROW_IN_DFLT,
  parameter int COL_IN     = COL_IN_DFLT,
  parameter int ROW_CW     = cnt_w(ROW_IN),
  parameter int COL_CW     = cnt_w(COL_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [ROW_CW-1:0]            wr_row,
  input  logic [DATA_WIDTH*COL_IN-1:0] wr_data,
  input  logic [COL_CW-1:0]            rd_col,
  output logic [DATA_WIDTH*ROW_IN-1:0] rd_data
);

  genvar gi;
  generate
    for (gi = 0; gi < ROW_IN; gi++) begin : g_row
      logic [DATA_WIDTH*COL_IN-1:0] row_reg;
      logic [DATA_WIDTH-1:0]        col_sel;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          row_reg <= '0;
        end else if (we && (wr_row == ROW_CW'(gi))) begin
          row_reg <= wr_data;
        end
      end

      // Explicit compare-mux keeps every slice in range even when COL_IN
      // is not a power of two.
      always_comb begin
        col_sel = '0;
        for (int c = 0; c < COL_IN; c++) begin
          if (rd_col == COL_CW'(c)) begin
            col_sel = row_reg[elem_lsb(c, DATA_WIDTH) +: DATA_WIDTH];
          end
        end
      end

      assign rd_data[elem_lsb(gi, DATA_WIDTH) +: DATA_WIDTH] = col_sel;
    end
  endgenerate

endmodule

// File: rtl/stream_transpose.sv
// stream_transpose -- double-buffered streaming matrix transpose.
// Takes a ROW_IN x COL_IN matrix one row per beat and emits its transpose one
// input column per beat. Two ping-pong banks let the next matrix load while
// the current one drains.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous abort of all buffered / partial matrices
//   in_valid/in_ready   : input row handshake, in_data = one row (element j at j*DATA_WIDTH)
//   out_valid/out_ready : output row handshake, out_data = one column (element r at r*DATA_WIDTH)
//   out_last            : marks the final column of each matrix
module stream_transpose
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
  parameter int ROW_IN     = ROW_IN_DFLT,
  parameter int COL_IN     = COL_IN_DFLT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH*COL_IN-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH*ROW_IN-1:0] out_data,
  output logic                         out_last
);

  localparam int ROW_CW = cnt_w(ROW_IN);
  localparam int COL_CW = cnt_w(COL_IN);

  logic              wr_bank_reg, wr_bank_next;
  logic              rd_bank_reg, rd_bank_next;
  logic [ROW_CW-1:0] wr_row_reg,  wr_row_next;
  logic [COL_CW-1:0] rd_col_reg,  rd_col_next;
  logic [1:0]        full_reg,    full_next;

  logic in_fire;
  logic out_fire;

  logic [DATA_WIDTH*ROW_IN-1:0] bank_rd_data [2];

  // Ready/valid come only from registered flags, so there is no path from
  // in_* to out_* nor from out_ready to in_ready.
  assign in_ready  = !full_reg[wr_bank_reg];
  assign out_valid = full_reg[rd_bank_reg];
  assign out_last  = out_valid && (rd_col_reg == COL_CW'(COL_IN - 1));
  assign out_data  = bank_rd_data[rd_bank_reg];

  // clear wins over both handshakes: a beat offered alongside it is dropped.
  assign in_fire  = in_valid && in_ready && !clear;
  assign out_fire = out_valid && out_ready && !clear;

  always_comb begin
    wr_bank_next = wr_bank_reg;
    rd_bank_next = rd_bank_reg;
    wr_row_next  = wr_row_reg;
    rd_col_next  = rd_col_reg;
    full_next    = full_reg;

    if (in_fire) begin
      if (wr_row_reg == ROW_CW'(ROW_IN - 1)) begin
        wr_row_next            = '0;
        full_next[wr_bank_reg] = 1'b1;
        wr_bank_next           = !wr_bank_reg;
      end else begin
        wr_row_next = wr_row_reg + ROW_CW'(1);
      end
    end

    // A fill completes only into an empty bank and a drain only frees a full
    // one, so the two updates above and below never touch the same flag.
    if (out_fire) begin
      if (out_last) begin
        rd_col_next            = '0;
        full_next[rd_bank_reg] = 1'b0;
        rd_bank_next           = !rd_bank_reg;
      end else begin
        rd_col_next = rd_col_reg + COL_CW'(1);
      end
    end

    if (clear) begin
      wr_bank_next = 1'b0;
      rd_bank_next = 1'b0;
      wr_row_next  = '0;
      rd_col_next  = '0;
      full_next    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_reg <= 1'b0;
      rd_bank_reg <= 1'b0;
      wr_row_reg  <= '0;
      rd_col_reg  <= '0;
      full_reg    <= '0;
    end else begin
      wr_bank_reg <= wr_bank_next;
      rd_bank_reg <= rd_bank_next;
      wr_row_reg  <= wr_row_next;
      rd_col_reg  <= rd_col_next;
      full_reg    <= full_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      transpose_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROW_IN     (ROW_IN),
        .COL_IN     (COL_IN),
        .ROW_CW     (ROW_CW),
        .COL_CW     (COL_CW)
      ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (in_fire && (wr_bank_reg == 1'(gi))),
        .wr_row  (wr_row_reg),
        .wr_data (in_data),
        .rd_col  (rd_col_reg),
        .rd_data (bank_rd_data[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_stream_transpose.sv
module tb_stream_transpose;

  localparam int DW = 16;
  localparam int RI = 8;
  localparam int CI = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic in_valid, in_ready, out_valid, out_ready, out_last;
  logic [DW*CI-1:0] in_data;
  logic [DW*RI-1:0] out_data;

  // second instance: ROW_IN=3, COL_IN=5, DATA_WIDTH=8
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [39:0] b_in_data;
  logic [23:0] b_out_data;

  always #5 clk = ~clk;

  stream_transpose #(.DATA_WIDTH(DW), .ROW_IN(RI), .COL_IN(CI)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  stream_transpose #(.DATA_WIDTH(8), .ROW_IN(3), .COL_IN(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // element (r,c) of matrix m: r*16+c, tagged with the matrix number above
  function automatic logic [15:0] elem(input int m, input int r, input int c);
    return 16'((m % 256) * 256 + r * 16 + c);
  endfunction

  function automatic logic [63:0] row_word(input int m, input int r);
    logic [63:0] w;
    w = '0;
    for (int c = 0; c < CI; c++) w[c*16 +: 16] = elem(m, r, c);
    return w;
  endfunction

  function automatic logic [127:0] beat(input int m, input int c);
    logic [127:0] b;
    b = '0;
    for (int r = 0; r < RI; r++) b[r*16 +: 16] = elem(m, r, c);
    return b;
  endfunction

  function automatic logic [39:0] brow(input int idx);
    logic [39:0] w;
    int k, r;
    k = idx / 3;
    r = idx % 3;
    w = '0;
    for (int c = 0; c < 5; c++) w[c*8 +: 8] = 8'(k * 128 + r * 16 + c);
    return w;
  endfunction

  // scoreboard state
  int feed_m = 0, feed_r = 0, feed_target = 0;
  int exp_m = 0, exp_c = 0, last_seen = 0, ir_drops = 0;
  bit prev_stall = 0, prev_last = 0, fired_last = 0;
  bit s_ov, s_ir, s_last;
  logic [127:0] prev_data, s_data;

  // One clock of traffic on the main instance: sample, check, then drive.
  task automatic cycle(input bit iv, input bit ordy);
    bit want;
    @(negedge clk);
    s_ov = out_valid; s_ir = in_ready; s_last = out_last; s_data = out_data;
    fired_last = 0;
    if (prev_stall) begin
      check("hold_data", out_data, prev_data);
      check("hold_last", 128'(out_last), 128'(prev_last));
    end
    want      = iv && (feed_m < feed_target);
    in_valid  = want;
    in_data   = row_word(feed_m, feed_r);
    out_ready = ordy;
    if (want && !in_ready) ir_drops++;
    if (out_valid && ordy) begin
      $display("out m=%0d c=%0d data=%0h last=%0b", exp_m, exp_c, out_data, out_last);
      check("beat_data", out_data, beat(exp_m, exp_c));
      check("beat_last", 128'(out_last), 128'(exp_c == CI - 1));
      if (exp_c == CI - 1) begin
        exp_c = 0; exp_m++; last_seen++; fired_last = 1;
      end else begin
        exp_c++;
      end
    end
    if (want && in_ready) begin
      if (feed_r == RI - 1) begin feed_r = 0; feed_m++; end
      else feed_r++;
    end
    prev_stall = out_valid && !ordy;
    prev_data  = out_data;
    prev_last  = out_last;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && exp_m < feed_target; i++) cycle(1'b1, 1'b1);
    check(tag, 128'(exp_m), 128'(feed_target));
  endtask

  logic [23:0] b_exp [10] = '{24'h201000, 24'h211101, 24'h221202, 24'h231303, 24'h241404,
                              24'hA09080, 24'hA19181, 24'hA29282, 24'hA39383, 24'hA49484};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rows_before, bi, bo;
    rst_n = 1'b0; clear = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_in_ready",   128'(in_ready),   128'(1));
    check("rst_out_valid",  128'(out_valid),  128'(0));
    check("rst_out_last",   128'(out_last),   128'(0));
    check("rst_out_data",   out_data,         128'(0));
    check("rst_b_in_ready", 128'(b_in_ready), 128'(1));
    check("rst_b_out_valid",128'(b_out_valid),128'(0));
    rst_n = 1'b1;

    // single matrix, latency and first beat
    feed_target = 1;
    for (int r = 0; r < RI; r++) cycle(1'b1, 1'b1);
    check("t1_valid_at_row7", 128'(s_ov), 128'(0));
    cycle(1'b1, 1'b1);
    check("t1_latency_valid", 128'(s_ov), 128'(1));
    check("t1_beat0_const", s_data, 128'h0070_0060_0050_0040_0030_0020_0010_0000);
    check("t1_beat0_last", 128'(s_last), 128'(0));
    drain("t1_done");
    check("t1_last_count", 128'(last_seen), 128'(1));

    // three back-to-back matrices, both sides always ready
    feed_target = 4; ir_drops = 0;
    for (int i = 0; i < 3 * RI; i++) cycle(1'b1, 1'b1);
    drain("t2_done");
    check("t2_in_ready_drops", 128'(ir_drops), 128'(0));

    // output stalled: two banks fill, then release
    feed_target = 7;
    rows_before = feed_m * RI + feed_r;
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0);
    check("t3_rows_accepted", 128'(feed_m * RI + feed_r - rows_before), 128'(16));
    check("t3_in_ready_low", 128'(s_ir), 128'(0));
    for (int i = 0; i < 10 && !fired_last; i++) cycle(1'b1, 1'b1);
    check("t3_first_last", 128'(fired_last), 128'(1));
    check("t3_ready_at_last", 128'(s_ir), 128'(0));
    cycle(1'b1, 1'b1);
    check("t3_ready_after", 128'(s_ir), 128'(1));
    drain("t3_done");

    // random valid / ready over 20 matrices
    feed_target = feed_target + 20;
    for (int i = 0; i < 3000 && exp_m < feed_target; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("t4_done", 128'(exp_m), 128'(feed_target));

    // clear while matrix A is mid-drain and matrix B has 5 rows
    feed_target = feed_m + 2;
    for (int i = 0; i < RI; i++) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1); cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
    check("t5_rows_of_b", 128'(feed_r), 128'(5));
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = row_word(feed_m, feed_r); out_ready = 1'b1;
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("t5_clr_out_valid", 128'(out_valid), 128'(0));
    check("t5_clr_in_ready",  128'(in_ready),  128'(1));
    check("t5_clr_out_last",  128'(out_last),  128'(0));
    feed_m = feed_m + 1; feed_r = 0;
    exp_m = feed_m; exp_c = 0;
    feed_target = feed_m + 1; prev_stall = 0;
    drain("t5_done");

    // 3x5 instance, two matrices, output always ready
    b_out_ready = 1'b1;
    bi = 0; bo = 0;
    for (int i = 0; i < 60 && bo < 10; i++) begin
      @(negedge clk);
      if (b_out_valid) begin
        $display("b out beat=%0d data=%0h last=%0b", bo, b_out_data, b_out_last);
        check("b_data", 128'(b_out_data), 128'(b_exp[bo]));
        check("b_last", 128'(b_out_last), 128'(bo % 5 == 4));
        bo++;
      end
      b_in_valid = (bi < 6);
      b_in_data  = brow(bi);
      if (bi < 6 && b_in_ready) bi++;
    end
    b_in_valid = 1'b0;
    check("b_done", 128'(bo), 128'(10));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_transpose.md
# stream_transpose

Streaming, double-buffered matrix transpose for the attention datapath. Accepts a ROW_IN × COL_IN matrix one row per beat over a valid/ready input. Emits its transpose one output row per beat (one input column per beat) over a valid/ready output. Two ping-pong banks let matrix N+1 load while matrix N drains, so K/V tiles stream into the score multiplier without stalls.

## Interface
- DATA_WIDTH, 16, bits per element
- ROW_IN, 8, rows of input matrix (≥2); equals output row width
- COL_IN, 4, columns of input matrix (≥2); equals number of output beats
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous abort; discards all buffered/partial matrices
- in_valid  in  1  input row valid
- in_ready  out  1  input row accepted when in_valid & in_ready
- in_data  in  DATA_WIDTH*COL_IN  one row; element j at bits [DATA_WIDTH*(j+1)-1 : DATA_WIDTH*j]
- out_valid  out  1  output row valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH*ROW_IN  one transposed row; element r = input (r, current column)
- out_last  out  1  high with the final output beat (column COL_IN-1) of each matrix

## Operation
- Storage: two banks, each ROW_IN × COL_IN elements, plus per-bank full flag.
- Write side: wr_bank pointer, wr_row counter (0..ROW_IN-1). in_ready = !full[wr_bank]. On accept, row stored at wr_row of wr_bank and wr_row increments. On accept with wr_row = ROW_IN-1: wr_row wraps to 0, full[wr_bank] set, wr_bank toggles.
- Read side: rd_bank pointer, rd_col counter (0..COL_IN-1). out_valid = full[rd_bank]. out_data element r = bank[rd_bank][r][rd_col]. out_last = out_valid & (rd_col = COL_IN-1). On out handshake rd_col increments. On handshake with out_last: rd_col wraps to 0, full[rd_bank] cleared, rd_bank toggles.
- Matrix boundaries are implicit from the counters. There is no input last flag.
- out_data, out_valid and out_last are driven from registers through the column mux. There is no combinational path from in_* to out_* or from out_ready to in_ready.
- clear: wr_row, rd_col, wr_bank, rd_bank and both full flags go to 0 next edge. Storage is not cleared. A beat presented in the same cycle as clear is dropped. clear has priority over every handshake.

## Timing
- Reset (rst_n low, asynchronous): counters, pointers, full flags and storage = 0. Therefore in_ready=1, out_valid=0, out_last=0, out_data=0.
- Latency: out_valid rises the cycle after the edge that accepts the last input row.
- Throughput: one input row and one output row per cycle concurrently. A matrix takes max(ROW_IN, COL_IN) cycles sustained when both sides are always ready.
- Both banks full: in_ready=0 until the read side releases a bank. in_ready rises the cycle after that out_last handshake (one bubble, registered flag).
- Fill and drain in the same cycle on different banks: both take effect. Bank states are independent.
- out_valid high with out_ready low: out_data and out_last hold stable.
- Async reset mid-matrix: partial contents are lost. The next accepted row is row 0 of bank 0.

## Structure
- Shared package attn_pkg holds:
  - ROW_W = $clog2(ROW_IN) and COL_W = $clog2(COL_IN) counter widths
  - the element-slice helper used by Transpose-family blocks
- Sub-module transpose_bank:
  - one ROW_IN × COL_IN register array with write-row port (we, row index, row data) and read-column port (column index → ROW_IN-element vector)
  - instantiated twice
- Top holds pointers, counters, full flags and output mux.

## Test plan
- Single matrix, defaults, element (r,c)=r*16+c, out_ready=1 -> four output beats. Beat c carries elements {7*16+c,…,c}. out_last only on beat 3. out_valid first high the cycle after row 7 is accepted.
- Three back-to-back matrices, in_valid and out_ready always 1 -> in_ready never drops. Outputs are in order. Each matrix's beats match its transpose.
- out_ready=0 throughout, feed 3 matrices -> in_ready falls after 16 accepted rows. Then raise out_ready -> in_ready returns the cycle after the first out_last handshake.
- Random out_ready toggling (50%) with random in_valid over 20 matrices -> out_data/out_last stable while stalled. All data matches the scoreboard transpose.
- clear asserted after 5 rows of matrix 2 while matrix 1 is mid-drain -> next cycle out_valid=0, in_ready=1. The next matrix fed is output intact as a fresh matrix.
- ROW_IN=3, COL_IN=5, DATA_WIDTH=8 -> five output beats of 24 bits. Wrap and out_last are correct.
